// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: serialises per-core data-memory requests onto one
// synchronous single-port RAM. Only one access is in flight at a time, and
// each access walks the states IDLE -> ACCESS -> CAPTURE -> ACK.
//
// Ports:
//   CLK, RSTn      clock (rising edge) and asynchronous active-low reset
//   Mem_Ctrl_bus   per-core command, core i on [4i+3:4i] (READ/WRITE request)
//   DAddress_bus   per-core address, core i on [8i+7:8i]
//   Ddout_bus      per-core write data, core i on [8i+7:8i]
//   Ddin           read data broadcast to all cores (holds the last read)
//   dacq           per-core one-cycle acknowledge
//   ram_addr/ram_wdata/ram_we/ram_re  RAM request side
//   ram_rdata      RAM read data, valid the cycle after ram_re
//   grant_id       index of the core being serviced (held after completion)
//   arb_busy       high whenever the FSM is not in IDLE
//
// Build option: define DMARB_FIXED_PRIO_EN to replace round-robin with
// fixed lowest-index-first priority. Timing is identical in both builds.
module data_mem_arbiter #(
  parameter int NCORES = 4
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic [4*NCORES-1:0]   Mem_Ctrl_bus,
  input  logic [8*NCORES-1:0]   DAddress_bus,
  input  logic [8*NCORES-1:0]   Ddout_bus,
  output logic [7:0]            Ddin,
  output logic [NCORES-1:0]     dacq,
  output logic [7:0]            ram_addr,
  output logic [7:0]            ram_wdata,
  output logic                  ram_we,
  output logic                  ram_re,
  input  logic [7:0]            ram_rdata,
  output logic [2:0]            grant_id,
  output logic                  arb_busy
);

  localparam int unsigned IDW = 3;
  localparam int unsigned DW  = 8;
  localparam int unsigned CW  = 4;

  // Command codes; any other value (including idle 4'h0) is no request.
  localparam logic [CW-1:0] MEM_READ  = 4'h1;
  localparam logic [CW-1:0] MEM_WRITE = 4'h2;

  localparam logic [IDW-1:0] LAST_RST = IDW'(NCORES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_CAPTURE,
    S_ACK
  } state_t;

  state_t state, state_d;

  logic [NCORES-1:0] req;
  logic              found;
  logic [IDW-1:0]    sel;
  logic [CW-1:0]     sel_ctrl;
  logic [DW-1:0]     sel_addr;
  logic [DW-1:0]     sel_wdata;

  logic [IDW-1:0]    last, last_d;
  logic              is_write, is_write_d;
  logic [IDW-1:0]    grant_d;
  logic [DW-1:0]     addr_d, wdata_d, ddin_d;
  logic              we_d, re_d, busy_d;
  logic [NCORES-1:0] dacq_d;

  // Per-core request decode.
  always_comb begin
    req = '0;
    for (int i = 0; i < NCORES; i++) begin
      req[i] = (Mem_Ctrl_bus[CW*i +: CW] == MEM_READ) ||
               (Mem_Ctrl_bus[CW*i +: CW] == MEM_WRITE);
    end
  end

`ifdef DMARB_FIXED_PRIO_EN
  // Lowest-index requester wins; scan high to low so the last hit is lowest.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        sel   = IDW'(i);
      end
    end
  end
`else
  logic [7:0] req_ext;
  logic [3:0] rr_sum;

  // Round-robin: first requester at last+1, last+2, ... modulo NCORES.
  always_comb begin
    found   = 1'b0;
    sel     = '0;
    rr_sum  = '0;
    req_ext = 8'(req);
    for (int k = 1; k <= NCORES; k++) begin
      rr_sum = 4'(last) + 4'(k);
      if (rr_sum >= 4'(NCORES)) begin
        rr_sum = rr_sum - 4'(NCORES);
      end
      if (!found && req_ext[rr_sum[2:0]]) begin
        found = 1'b1;
        sel   = rr_sum[2:0];
      end
    end
  end
`endif

  // Payload of the selected core.
  always_comb begin
    sel_ctrl  = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (sel == IDW'(i)) begin
        sel_ctrl  = Mem_Ctrl_bus[CW*i +: CW];
        sel_addr  = DAddress_bus[DW*i +: DW];
        sel_wdata = Ddout_bus[DW*i +: DW];
      end
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d    = state;
    last_d     = last;
    is_write_d = is_write;
    grant_d    = grant_id;
    addr_d     = ram_addr;
    wdata_d    = ram_wdata;
    ddin_d     = Ddin;
    we_d       = 1'b0;
    re_d       = 1'b0;
    dacq_d     = '0;

    unique case (state)
      S_IDLE: begin
        if (found) begin
          grant_d    = sel;
`ifndef DMARB_FIXED_PRIO_EN
          last_d     = sel;
`endif
          is_write_d = (sel_ctrl == MEM_WRITE);
          addr_d     = sel_addr;
          wdata_d    = sel_wdata;
          we_d       = (sel_ctrl == MEM_WRITE);
          re_d       = (sel_ctrl != MEM_WRITE);
          state_d    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // RAM data for the read strobed in ACCESS is valid now.
        if (!is_write) begin
          ddin_d = ram_rdata;
        end
        dacq_d  = NCORES'(1) << grant_id;
        state_d = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      last      <= LAST_RST;
      is_write  <= 1'b0;
      grant_id  <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
      Ddin      <= '0;
      dacq      <= '0;
      arb_busy  <= 1'b0;
    end else begin
      last      <= last_d;
      is_write  <= is_write_d;
      grant_id  <= grant_d;
      ram_addr  <= addr_d;
      ram_wdata <= wdata_d;
      ram_we    <= we_d;
      ram_re    <= re_d;
      Ddin      <= ddin_d;
      dacq      <= dacq_d;
      arb_busy  <= busy_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter (NCORES=4) with a behavioural RAM.
module tb_data_mem_arbiter;

  localparam int NC = 4;
  localparam logic [3:0] MI = 4'h0;
  localparam logic [3:0] MR = 4'h1;
  localparam logic [3:0] MW = 4'h2;

  logic            CLK = 1'b0;
  logic            RSTn = 1'b0;
  logic [4*NC-1:0] Mem_Ctrl_bus;
  logic [8*NC-1:0] DAddress_bus;
  logic [8*NC-1:0] Ddout_bus;
  logic [7:0]      Ddin;
  logic [NC-1:0]   dacq;
  logic [7:0]      ram_addr;
  logic [7:0]      ram_wdata;
  logic            ram_we;
  logic            ram_re;
  logic [7:0]      ram_rdata = 8'h00;
  logic [2:0]      grant_id;
  logic            arb_busy;

  logic [3:0] ctrl [NC];
  logic [7:0] adr  [NC];
  logic [7:0] wd   [NC];
  logic [7:0] mem  [256];

  int checks = 0;
  int errors = 0;

  data_mem_arbiter #(.NCORES(NC)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .Mem_Ctrl_bus(Mem_Ctrl_bus), .DAddress_bus(DAddress_bus), .Ddout_bus(Ddout_bus),
    .Ddin(Ddin), .dacq(dacq),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata), .grant_id(grant_id), .arb_busy(arb_busy)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    for (int i = 0; i < NC; i++) begin
      Mem_Ctrl_bus[4*i +: 4] = ctrl[i];
      DAddress_bus[8*i +: 8] = adr[i];
      Ddout_bus[8*i +: 8]    = wd[i];
    end
  end

  // Synchronous single-port RAM: read data valid the cycle after ram_re.
  always @(posedge CLK) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_req();
    for (int i = 0; i < NC; i++) begin
      ctrl[i] = MI;
      adr[i]  = 8'h00;
      wd[i]   = 8'h00;
    end
  endtask

  task automatic set_req(input int c, input logic [3:0] cc, input logic [7:0] a, input logic [7:0] d);
    ctrl[c] = cc;
    adr[c]  = a;
    wd[c]   = d;
  endtask

  // Advance to the next negedge with an ack, bounded; checks the acked core.
  task automatic expect_ack(input string nm, input int core);
    int cyc;
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (dacq == '0 && cyc < 12);
    if (dacq == '0) chk({nm, "_timeout"}, 32'd0, 32'd1);
    else begin
      chk(nm, 32'(dacq), 32'(1) << core);
      chk({nm, "_gid"}, 32'(grant_id), 32'(core));
    end
  endtask

  typedef struct {
    int         core;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_ddin;
  } vec_t;

  vec_t vt[8];

  initial begin
    clr_req();
    vt[0] = '{1, 1'b1, 8'h10, 8'h5A, 8'h00};
    vt[1] = '{1, 1'b0, 8'h10, 8'h00, 8'h5A};
    vt[2] = '{2, 1'b1, 8'h30, 8'hC3, 8'h5A};
    vt[3] = '{0, 1'b1, 8'h44, 8'h11, 8'h5A};
    vt[4] = '{3, 1'b0, 8'h44, 8'h00, 8'h11};
    vt[5] = '{2, 1'b0, 8'h30, 8'h00, 8'hC3};
    vt[6] = '{1, 1'b1, 8'h50, 8'h99, 8'hC3};
    vt[7] = '{3, 1'b0, 8'h50, 8'h00, 8'h99};

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_dacq", 32'(dacq), 0);
    chk("rst_strobes", {30'd0, ram_we, ram_re}, 0);
    chk("rst_busy", 32'(arb_busy), 0);
    chk("rst_ddin", 32'(Ddin), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_gid", 32'(grant_id), 0);
    RSTn = 1'b1;
    @(negedge CLK);

    // Single-core transactions with exact cycle timing
    for (int v = 0; v < 8; v++) begin
      set_req(vt[v].core, vt[v].wr ? MW : MR, vt[v].addr, vt[v].wdata);
      @(negedge CLK);
      chk("c1_we", 32'(ram_we), 32'(vt[v].wr));
      chk("c1_re", 32'(ram_re), 32'(!vt[v].wr));
      chk("c1_addr", 32'(ram_addr), 32'(vt[v].addr));
      chk("c1_gid", 32'(grant_id), 32'(vt[v].core));
      chk("c1_busy", 32'(arb_busy), 1);
      if (vt[v].wr) chk("c1_wdata", 32'(ram_wdata), 32'(vt[v].wdata));
      @(negedge CLK);
      chk("c2_quiet", {27'd0, ram_we, ram_re, dacq}, 0);
      @(negedge CLK);
      chk("c3_dacq", 32'(dacq), 32'(1) << vt[v].core);
      chk("c3_ddin", 32'(Ddin), 32'(vt[v].exp_ddin));
      clr_req();
      @(negedge CLK);
      chk("c4_dacq", 32'(dacq), 0);
      chk("c4_busy", 32'(arb_busy), 0);
    end

    // All four cores request out of reset, each held until its ack
    RSTn = 1'b0;
    @(negedge CLK);
    for (int c = 0; c < NC; c++) set_req(c, MR, 8'h10 + 8'(c), 8'h00);
    RSTn = 1'b1;
    for (int n = 0; n < NC; n++) begin
      expect_ack("all4_order", n);
      ctrl[n] = MI;
    end
    @(negedge CLK);
    chk("all4_idle", 32'(arb_busy), 0);

    // Cores 0 and 2 requesting continuously
    set_req(0, MR, 8'h30, 8'h00);
    set_req(2, MR, 8'h44, 8'h00);
    for (int n = 0; n < 4; n++) begin
`ifdef DMARB_FIXED_PRIO_EN
      expect_ack("cont_order", 0);
`else
      expect_ack("cont_order", (n % 2 == 0) ? 0 : 2);
`endif
    end
    clr_req();
    repeat (4) @(negedge CLK);

    // Illegal command code is not a request
    set_req(3, 4'hF, 8'h10, 8'hEE);
    for (int n = 0; n < 6; n++) begin
      @(negedge CLK);
      chk("illegal_quiet", {27'd0, arb_busy, ram_we, ram_re, dacq}, 0);
    end
    clr_req();

    // Reset during CAPTURE of a read by core 0
    @(negedge CLK);
    set_req(0, MR, 8'h20, 8'h00);
    @(negedge CLK);
    chk("mid_re", 32'(ram_re), 1);
    @(negedge CLK);
    RSTn = 1'b0;
    #1;
    chk("mid_dacq", 32'(dacq), 0);
    chk("mid_busy", 32'(arb_busy), 0);
    chk("mid_ddin", 32'(Ddin), 0);
    chk("mid_addr", 32'(ram_addr), 0);
    chk("mid_gid", 32'(grant_id), 0);
    set_req(2, MR, 8'h44, 8'h00);
    @(negedge CLK);
    chk("mid_hold_dacq", 32'(dacq), 0);
    RSTn = 1'b1;
    expect_ack("post_rst_first", 0);
    ctrl[0] = MI;
    expect_ack("post_rst_second", 2);
    chk("post_rst_ddin", 32'(Ddin), 32'h11);
    clr_req();
    repeat (2) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
